// File: rtl/mat_vec_feeder.sv
// mat_vec_feeder: latches a 4x4 matrix, streams vertices into an external
// mat_vec_mul with credit-based flow control, and queues the multiplier
// results (tagged with the batch-end marker) in a small result FIFO.
module mat_vec_feeder #(
    parameter int DATAWIDTH   = 18,
    parameter int FRACBITS    = 12,
    parameter int MUL_LATENCY = 5,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic signed [DATAWIDTH-1:0] i_mat [4][4],
    input  logic                        i_mat_load,
    input  logic signed [DATAWIDTH-1:0] s_vtx [4],
    input  logic                        s_valid,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic signed [DATAWIDTH-1:0] o_A [4][4],
    output logic signed [DATAWIDTH-1:0] o_x [4],
    output logic                        o_dv,
    input  logic signed [DATAWIDTH-1:0] i_y [4],
    input  logic                        i_y_dv,
    output logic signed [DATAWIDTH-1:0] m_y [4],
    output logic                        m_valid,
    output logic                        m_last,
    input  logic                        m_ready,
    output logic                        busy,
    output logic                        o_err
);

    // FRACBITS only describes the number format; it never enters the datapath.
    if (FIFO_DEPTH < MUL_LATENCY + 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || FRACBITS >= DATAWIDTH) begin : g_param_check
        $error("mat_vec_feeder: illegal parameter combination");
    end

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_S = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                      state_q, state_d;
    logic signed [DATAWIDTH-1:0] mat_q [4][4];
    logic signed [DATAWIDTH-1:0] mat_d [4][4];
    logic signed [DATAWIDTH-1:0] x_q [4];
    logic signed [DATAWIDTH-1:0] x_d [4];
    logic                        dv_q, dv_d;
    logic [MUL_LATENCY:0]        tag_q, tag_d;
    logic [CW-1:0]               count_q, count_d;
    logic [CW-1:0]               inflight_q, inflight_d;
    logic [PW-1:0]               wptr_q, wptr_d;
    logic [PW-1:0]               rptr_q, rptr_d;
    logic                        err_q, err_d;
    logic signed [DATAWIDTH-1:0] ymem_q [FIFO_DEPTH][4];
    logic signed [DATAWIDTH-1:0] ymem_d [FIFO_DEPTH][4];
    logic [FIFO_DEPTH-1:0]       lmem_q, lmem_d;

    logic [CW:0] used;
    logic        accept;
    logic        pop;
    logic        full;
    logic        have_inflight;
    logic        wr;
    logic        dec;

    // Credit check and handshake qualifiers from registered state only.
    always_comb begin
        used          = {1'b0, count_q} + {1'b0, inflight_q};
        s_ready       = (state_q == RUN) && (used < DEPTH_S);
        accept        = s_valid && s_ready;
        m_valid       = (count_q != '0);
        pop           = m_valid && m_ready;
        full          = (count_q == DEPTH_C);
        have_inflight = (inflight_q != '0);
        wr            = i_y_dv && !full && have_inflight;
        dec           = i_y_dv && have_inflight;
    end

    // FSM next state and matrix latch (loads honoured only in IDLE).
    always_comb begin
        state_d = state_q;
        mat_d   = mat_q;
        case (state_q)
            IDLE: begin
                if (i_mat_load) begin
                    mat_d   = i_mat;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept && s_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!have_inflight && count_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Vertex launch, last-tag alignment, in-flight tracking, FIFO and error flag.
    always_comb begin
        x_d    = x_q;
        dv_d   = accept;
        tag_d  = {tag_q[MUL_LATENCY-1:0], accept & s_last};
        ymem_d = ymem_q;
        lmem_d = lmem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (accept) begin
            x_d = s_vtx;
        end
        if (wr) begin
            ymem_d[wptr_q] = i_y;
            lmem_d[wptr_q] = tag_q[MUL_LATENCY];
            wptr_d         = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({wr, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        case ({accept, dec})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
        err_d = err_q | (i_y_dv && (full || !have_inflight));
    end

    // Control and data registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            mat_q      <= '{default: '{default: '0}};
            x_q        <= '{default: '0};
            dv_q       <= 1'b0;
            tag_q      <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mat_q      <= mat_d;
            x_q        <= x_d;
            dv_q       <= dv_d;
            tag_q      <= tag_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            err_q      <= err_d;
        end
    end

    // FIFO storage; contents are masked by count, so no reset is needed.
    always_ff @(posedge clk) begin
        ymem_q <= ymem_d;
        lmem_q <= lmem_d;
    end

    // Outputs; the FIFO head is forced to zero whenever the FIFO is empty.
    always_comb begin
        o_A    = mat_q;
        o_x    = x_q;
        o_dv   = dv_q;
        busy   = (state_q != IDLE);
        o_err  = err_q;
        m_last = m_valid & lmem_q[rptr_q];
        for (int i = 0; i < 4; i++) begin
            m_y[i] = m_valid ? ymem_q[rptr_q][i] : '0;
        end
    end

endmodule

// File: tb/tb_mat_vec_feeder.sv
// Bench for mat_vec_feeder with a behavioural 5-cycle mat_vec_mul model.
module tb_mat_vec_feeder;

    localparam int DW = 18;
    localparam int FB = 12;
    localparam int ML = 5;
    localparam int FD = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rstn;
    logic signed [DW-1:0] i_mat [4][4];
    logic                 i_mat_load;
    logic signed [DW-1:0] s_vtx [4];
    logic                 s_valid, s_last, s_ready;
    logic signed [DW-1:0] o_A [4][4];
    logic signed [DW-1:0] o_x [4];
    logic                 o_dv;
    logic signed [DW-1:0] i_y [4];
    logic                 i_y_dv;
    logic signed [DW-1:0] m_y [4];
    logic                 m_valid, m_last, m_ready;
    logic                 busy, o_err;

    int errors = 0;
    int checks = 0;

    mat_vec_feeder #(
        .DATAWIDTH(DW), .FRACBITS(FB), .MUL_LATENCY(ML), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rstn(rstn), .i_mat(i_mat), .i_mat_load(i_mat_load),
        .s_vtx(s_vtx), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .o_A(o_A), .o_x(o_x), .o_dv(o_dv), .i_y(i_y), .i_y_dv(i_y_dv),
        .m_y(m_y), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .o_err(o_err)
    );

    // Behavioural multiplier: y = (A*x) >>> FB, delivered ML cycles after o_dv.
    logic [ML-1:0]        mul_v = '0;
    logic signed [DW-1:0] mul_y [ML][4];
    logic                 spur;
    logic signed [DW-1:0] spur_y [4];

    function automatic logic signed [DW-1:0] dot_row(input int i);
        longint acc;
        longint sh;
        acc = 0;
        for (int j = 0; j < 4; j++) acc += longint'(o_A[i][j]) * longint'(o_x[j]);
        sh = acc >>> FB;
        return sh[DW-1:0];
    endfunction

    always @(posedge clk) begin
        mul_v <= {mul_v[ML-2:0], o_dv};
        for (int s = ML - 1; s > 0; s--) mul_y[s] <= mul_y[s-1];
        for (int i = 0; i < 4; i++) mul_y[0][i] <= dot_row(i);
    end

    always_comb begin
        i_y_dv = mul_v[ML-1] | spur;
        for (int i = 0; i < 4; i++) i_y[i] = spur ? spur_y[i] : mul_y[ML-1][i];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_diag(input int d);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) i_mat[r][c] = (r == c) ? DW'(d) : '0;
    endtask

    task automatic set_vtx(input int a, input int b, input int c, input int d);
        s_vtx[0] = DW'(a); s_vtx[1] = DW'(b); s_vtx[2] = DW'(c); s_vtx[3] = DW'(d);
    endtask

    task automatic load_matrix(input int d);
        set_diag(d);
        i_mat_load = 1'b1;
        tick();
        i_mat_load = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %0b want 0", s_ready); end
        checks++; if (o_dv !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: o_dv=%0b m_valid=%0b m_last=%0b want 0", o_dv, m_valid, m_last); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", o_err); end
        checks++; if (o_A[2][2] !== '0 || o_x[0] !== '0) begin
            errors++; $display("FAIL reset_data: o_A22=%0d o_x0=%0d want 0", o_A[2][2], o_x[0]); end
        rstn = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: busy=%0b s_ready=%0b want 0", busy, s_ready); end
    endtask

    task automatic test_identity();
        load_matrix(4096);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL id_busy: got %0b want 1", busy); end
        checks++; if (o_A[1][1] !== 18'sd4096 || o_A[0][1] !== '0) begin
            errors++; $display("FAIL id_oA: o_A11=%0d o_A01=%0d want 4096 0", o_A[1][1], o_A[0][1]); end
        set_vtx(4096, 8192, -4096, 0);
        s_last = 1'b1; s_valid = 1'b1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL id_s_ready: got %0b want 1", s_ready); end
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        checks++; if (o_dv !== 1'b1 || o_x[1] !== 18'sd8192 || o_x[2] !== -18'sd4096) begin
            errors++; $display("FAIL id_launch: o_dv=%0b o_x1=%0d o_x2=%0d want 1 8192 -4096", o_dv, o_x[1], o_x[2]); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL id_drain_ready: got %0b want 0", s_ready); end
        tick();
        checks++; if (o_dv !== 1'b0) begin errors++; $display("FAIL id_dv_pulse: got %0b want 0", o_dv); end
        repeat (4) tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL id_early_valid: got %0b want 0", m_valid); end
        tick();
        checks++; if (m_valid !== 1'b1 || m_last !== 1'b1) begin
            errors++; $display("FAIL id_valid_at_7: m_valid=%0b m_last=%0b want 1 1", m_valid, m_last); end
        checks++; if (m_y[0] !== 18'sd4096 || m_y[1] !== 18'sd8192 || m_y[2] !== -18'sd4096 || m_y[3] !== '0) begin
            errors++; $display("FAIL id_m_y: got %0d %0d %0d %0d want 4096 8192 -4096 0", m_y[0], m_y[1], m_y[2], m_y[3]); end
        tick();
        checks++; if (m_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL id_drain: m_valid=%0b busy=%0b want 0 1", m_valid, busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL id_idle: busy=%0b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int oidx = 0;
        int cyc = 0;
        logic acc;
        logic signed [DW-1:0] exp_v [4];
        load_matrix(8192);
        while (oidx < 10 && cyc < 200) begin
            s_valid = (idx < 10);
            set_vtx(idx * 100, -idx * 50, idx * 7, 1000 - idx);
            s_last = (idx == 9);
            if (idx < 10) begin
                checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready v%0d: got %0b want 1", idx, s_ready); end
            end
            acc = s_valid && s_ready;
            if (m_valid) begin
                exp_v[0] = DW'(2 * oidx * 100); exp_v[1] = DW'(-2 * oidx * 50);
                exp_v[2] = DW'(2 * oidx * 7);   exp_v[3] = DW'(2 * (1000 - oidx));
                checks++; if (m_y[0] !== exp_v[0] || m_y[1] !== exp_v[1] || m_y[2] !== exp_v[2] || m_y[3] !== exp_v[3]) begin
                    errors++; $display("FAIL b2b_data r%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d", oidx,
                        m_y[0], m_y[1], m_y[2], m_y[3], exp_v[0], exp_v[1], exp_v[2], exp_v[3]); end
                checks++; if (m_last !== (oidx == 9)) begin
                    errors++; $display("FAIL b2b_last r%0d: got %0b want %0b", oidx, m_last, (oidx == 9)); end
                oidx++;
            end
            tick();
            if (acc) idx++;
            cyc++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        checks++; if (oidx != 10) begin errors++; $display("FAIL b2b_count: got %0d results want 10", oidx); end
        cyc = 0;
        while (busy && cyc < 20) begin tick(); cyc++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%0b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int acc_n = 0;
        int oidx = 0;
        int cyc = 0;
        logic acc;
        load_matrix(4096);
        m_ready = 1'b0;
        for (int c = 0; c < 25; c++) begin
            s_valid = 1'b1; s_last = 1'b0;
            set_vtx((acc_n + 1) * 16, -(acc_n + 1) * 16, acc_n + 1, 4096);
            acc = s_ready;
            tick();
            if (acc) acc_n++;
        end
        checks++; if (acc_n != 8) begin errors++; $display("FAIL bp_accepts: got %0d want 8", acc_n); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %0b want 0", s_ready); end
        checks++; if (m_valid !== 1'b1 || m_y[0] !== 18'sd16 || m_y[1] !== -18'sd16) begin
            errors++; $display("FAIL bp_hold: m_valid=%0b m_y0=%0d m_y1=%0d want 1 16 -16", m_valid, m_y[0], m_y[1]); end
        s_valid = 1'b0;
        m_ready = 1'b1;
        while (oidx < 8 && cyc < 50) begin
            if (m_valid) begin
                checks++; if (m_y[0] !== DW'((oidx + 1) * 16) || m_y[1] !== DW'(-(oidx + 1) * 16)
                              || m_y[2] !== DW'(oidx + 1) || m_y[3] !== 18'sd4096 || m_last !== 1'b0) begin
                    errors++; $display("FAIL bp_data r%0d: got %0d %0d %0d %0d last=%0b", oidx,
                        m_y[0], m_y[1], m_y[2], m_y[3], m_last); end
                oidx++;
            end
            tick();
            cyc++;
        end
        checks++; if (oidx != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", oidx); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL bp_err: got %0b want 0", o_err); end
        set_vtx(7, 7, 7, 7);
        s_valid = 1'b1; s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        cyc = 0;
        while (busy && cyc < 30) begin tick(); cyc++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: busy=%0b want 0", busy); end
    endtask

    task automatic test_load_in_run();
        int oidx = 0;
        int cyc = 0;
        load_matrix(4096);
        set_vtx(100, 200, 300, 400);
        s_valid = 1'b1; s_last = 1'b0;
        tick();
        s_valid = 1'b0;
        set_diag(8192);
        i_mat_load = 1'b1;
        tick();
        i_mat_load = 1'b0;
        tick();
        checks++; if (o_A[0][0] !== 18'sd4096 || o_A[3][3] !== 18'sd4096) begin
            errors++; $display("FAIL lir_oA: o_A00=%0d o_A33=%0d want 4096 4096", o_A[0][0], o_A[3][3]); end
        set_vtx(-8, 16, -24, 32);
        s_valid = 1'b1; s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        while (oidx < 2 && cyc < 40) begin
            if (m_valid) begin
                if (oidx == 0) begin
                    checks++; if (m_y[0] !== 18'sd100 || m_y[3] !== 18'sd400 || m_last !== 1'b0) begin
                        errors++; $display("FAIL lir_r0: got %0d %0d last=%0b want 100 400 0", m_y[0], m_y[3], m_last); end
                end else begin
                    checks++; if (m_y[0] !== -18'sd8 || m_y[3] !== 18'sd32 || m_last !== 1'b1) begin
                        errors++; $display("FAIL lir_r1: got %0d %0d last=%0b want -8 32 1", m_y[0], m_y[3], m_last); end
                end
                oidx++;
            end
            tick();
            cyc++;
        end
        checks++; if (oidx != 2) begin errors++; $display("FAIL lir_count: got %0d want 2", oidx); end
        cyc = 0;
        while (busy && cyc < 20) begin tick(); cyc++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lir_idle: busy=%0b want 0", busy); end
    endtask

    task automatic test_reset_mid_batch();
        logic seen = 1'b0;
        load_matrix(4096);
        s_valid = 1'b1; s_last = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_vtx(k + 1, k + 2, k + 3, k + 4);
            tick();
        end
        s_valid = 1'b0;
        rstn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || s_ready !== 1'b0 || o_dv !== 1'b0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL rmb_ctrl: busy=%0b s_ready=%0b o_dv=%0b m_valid=%0b want 0", busy, s_ready, o_dv, m_valid); end
        checks++; if (o_A[0][0] !== '0 || o_x[2] !== '0 || o_err !== 1'b0) begin
            errors++; $display("FAIL rmb_data: o_A00=%0d o_x2=%0d o_err=%0b want 0", o_A[0][0], o_x[2], o_err); end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (m_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmb_no_valid: m_valid seen=%0b want 0", seen); end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL rmb_err: got %0b want 1", o_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmb_idle: busy=%0b want 0", busy); end
    endtask

    task automatic test_spurious();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL sp_clear: got %0b want 0", o_err); end
        for (int i = 0; i < 4; i++) spur_y[i] = DW'(55 * (i + 1));
        spur = 1'b1;
        tick();
        spur = 1'b0;
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL sp_set: got %0b want 1", o_err); end
        repeat (3) tick();
        checks++; if (o_err !== 1'b1 || m_valid !== 1'b0) begin
            errors++; $display("FAIL sp_sticky: o_err=%0b m_valid=%0b want 1 0", o_err, m_valid); end
        rstn = 1'b0;
        #1;
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL sp_reset: got %0b want 0", o_err); end
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        rstn = 1'b0; i_mat_load = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        m_ready = 1'b1; spur = 1'b0;
        set_diag(0);
        set_vtx(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) spur_y[i] = '0;
        test_reset();
        test_identity();
        test_back_to_back();
        test_backpressure();
        test_load_in_run();
        test_reset_mid_batch();
        test_spurious();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mat_vec_feeder.md
MAT_VEC_FEEDER -- requirements
Module: mat_vec_feeder

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 18, fixed-point word width.
REQ-002 SHALL have parameter FRACBITS, default 12, fraction bits; used only for bench values, not for arithmetic.
REQ-003 SHALL have parameter MUL_LATENCY, default 5, cycles from o_dv to i_y_dv of the attached mat_vec_mul.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, result FIFO entries, power of two, >= MUL_LATENCY+1.
REQ-005 clk  in  1  single clock; everything sampled on rising edge.
REQ-006 rstn  in  1  asynchronous, active-low reset.
REQ-007 i_mat  in  signed [DATAWIDTH-1:0] [4][4]  matrix to latch.
REQ-008 i_mat_load  in  1  matrix load strobe.
REQ-009 s_vtx  in  signed [DATAWIDTH-1:0] [4]  upstream vertex.
REQ-010 s_valid / s_last  in  1 each  vertex valid / last vertex of batch.
REQ-011 s_ready  out  1  vertex accepted when s_valid && s_ready.
REQ-012 o_A  out  signed [DATAWIDTH-1:0] [4][4]  matrix to multiplier, driven from the matrix register.
REQ-013 o_x  out  signed [DATAWIDTH-1:0] [4]; o_dv  out  1  vertex and strobe to multiplier.
REQ-014 i_y  in  signed [DATAWIDTH-1:0] [4]; i_y_dv  in  1  multiplier result and strobe.
REQ-015 m_y  out  signed [DATAWIDTH-1:0] [4]; m_valid, m_last  out  1; m_ready  in  1  result stream.
REQ-016 busy  out  1  state != IDLE; o_err  out  1  sticky overflow flag.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-018 IDLE: i_mat_load=1 SHALL latch i_mat into the matrix register and move to RUN next cycle; i_mat_load in RUN/DRAIN SHALL be ignored.
REQ-019 credits = FIFO_DEPTH - fifo_count - inflight; s_ready SHALL be 1 only when state==RUN and credits>0 (combinational from registered state).
REQ-020 On accept, o_x SHALL take s_vtx and o_dv SHALL be 1 for exactly the following cycle; o_dv=0 otherwise, o_x holds its value.
REQ-021 inflight SHALL +1 on accept, -1 on i_y_dv, unchanged on both in one cycle; range 0..FIFO_DEPTH.
REQ-022 s_last SHALL be carried in a (MUL_LATENCY+1)-stage tag shift register aligned with i_y_dv, stored with i_y in the FIFO.
REQ-023 Accept with s_last=1 SHALL move RUN->DRAIN; s_ready=0 in DRAIN.
REQ-024 DRAIN->IDLE SHALL occur the cycle after inflight==0, FIFO empty and no accept/pop pending; a new matrix is then required.
REQ-025 i_y_dv SHALL write {i_y, tag} into the FIFO at that edge; m_valid SHALL assert the following cycle (accept-to-m_valid = MUL_LATENCY+2 cycles).
REQ-026 m_y/m_last SHALL be FIFO head; pop on m_valid && m_ready; simultaneous write and pop keeps count; pointers wrap modulo FIFO_DEPTH.
REQ-027 m_valid, m_y, m_last SHALL be held stable while m_valid && !m_ready.
REQ-028 i_y_dv with FIFO full SHALL drop the write and set o_err until reset; i_y_dv with inflight==0 SHALL also set o_err.
REQ-029 o_A SHALL be constant between loads; no arithmetic on data is performed.

Reset
REQ-030 rstn=0 SHALL immediately force state IDLE, matrix register, o_x, FIFO pointers, count, inflight, tags to 0; s_ready, o_dv, m_valid, m_last, busy, o_err = 0.
REQ-031 Reset mid-batch SHALL discard in-flight and queued results; i_y_dv arriving after release with inflight==0 sets o_err.

Verification (bench pairs block with a real mat_vec_mul)
REQ-032 Identity: load I (diagonal 4096), send x=(4096,8192,-4096,0) last=1 -> m_y=(4096,8192,-4096,0), m_last=1, m_valid 7 cycles after accept, then IDLE.
REQ-033 Scale: diag 8192, stream 10 vertices m_ready=1 -> outputs doubled, in order, only 10th has m_last, s_ready never drops while credits>0.
REQ-034 Backpressure: m_ready=0, continuous s_valid -> exactly 8 accepts then s_ready=0; release m_ready -> all 8 out, no o_err.
REQ-035 Load in RUN: i_mat_load with new matrix mid-batch -> ignored, o_A unchanged.
REQ-036 Reset mid-batch: rstn low with 3 in flight -> outputs zero immediately, busy=0, no m_valid after release.
REQ-037 Spurious i_y_dv from bench in IDLE -> o_err=1 sticky until reset.
